// File: rtl/ula_fx_seq.sv
// ula_fx_seq -- sequential fixed-point integer ALU (5-bit opcode map).
//
// Single-cycle operations register their result one edge after start.
// DIV, MOD and NRM use C semantics: the quotient truncates toward zero and
// the remainder takes the sign of the dividend. When the macro
// ULA_FX_SEQ_DIV_EN is defined, these three operations run on a shared
// restoring radix-2 divider with NUBITS+1 cycles of latency. When it is
// undefined, they are computed combinationally in one cycle and busy is
// held at 0.
//
// Parameters:
//   NUBITS - data word width (>= 4)
//   NUGAIN - signed divisor constant used by NRM (non-zero)
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous active-high reset
//   op          opcode, sampled with start
//   in1, in2    signed operands, sampled with start
//   start       request; accepted only while busy is 0
//   busy        a divider operation is in flight
//   valid       one-cycle pulse marking new out/is_zero/div_by_zero
//   out         registered result, held until the next valid
//   is_zero     out == 0
//   div_by_zero set with a DIV/MOD result whose divisor was zero
module ula_fx_seq #(
    parameter int NUBITS = 32,
    parameter int NUGAIN = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        op,
    input  logic [NUBITS-1:0] in1,
    input  logic [NUBITS-1:0] in2,
    input  logic              start,
    output logic              busy,
    output logic              valid,
    output logic [NUBITS-1:0] out,
    output logic              is_zero,
    output logic              div_by_zero
);
    localparam logic [4:0] OP_NOP = 5'd0,  OP_LOAD = 5'd1,  OP_ADD = 5'd2,  OP_MLT = 5'd3;
    localparam logic [4:0] OP_DIV = 5'd4,  OP_MOD  = 5'd5,  OP_NEG = 5'd6,  OP_NRM = 5'd7;
    localparam logic [4:0] OP_ABS = 5'd8,  OP_PST  = 5'd9,  OP_SGN = 5'd10, OP_OR  = 5'd11;
    localparam logic [4:0] OP_AND = 5'd12, OP_INV  = 5'd13, OP_XOR = 5'd14, OP_LES = 5'd15;
    localparam logic [4:0] OP_GRE = 5'd16, OP_EQU  = 5'd17, OP_LIN = 5'd18, OP_LAN = 5'd19;
    localparam logic [4:0] OP_LOR = 5'd20, OP_SHL  = 5'd21, OP_SHR = 5'd22, OP_SRS = 5'd23;

    localparam logic signed [NUBITS-1:0] GAIN = NUBITS'(NUGAIN);
    localparam logic signed [NUBITS-1:0] SMAX = {1'b0, {(NUBITS-1){1'b1}}};
    localparam logic signed [NUBITS-1:0] SMIN = {1'b1, {(NUBITS-1){1'b0}}};
    localparam int SHW = $clog2(NUBITS);
    localparam logic [NUBITS:0] SH_LIM = (NUBITS+1)'(NUBITS);

    // Magnitude as an unsigned word; |MIN| = 2^(NUBITS-1) still fits.
    function automatic logic [NUBITS-1:0] mag(input logic [NUBITS-1:0] v);
        return v[NUBITS-1] ? -v : v;
    endfunction

    // Restore C signs on a magnitude quotient/remainder pair.
    function automatic logic [NUBITS-1:0] apply_sign(input logic mod_sel, input logic neg_n,
                                                      input logic neg_d, input logic [NUBITS-1:0] q,
                                                      input logic [NUBITS-1:0] r);
        if (mod_sel)
            return neg_n ? -r : r;
        return (neg_n ^ neg_d) ? -q : q;
    endfunction

    // Shifts of in1 by the unsigned in2. Amounts of NUBITS or more flush the
    // word (SHL/SHR) or fill it with the sign bit (SRS).
    function automatic logic [NUBITS-1:0] shift_op(input logic [4:0] o, input logic [NUBITS-1:0] a,
                                                    input logic [NUBITS-1:0] b);
        logic            big;
        logic [SHW-1:0]  sh;
        logic [NUBITS-1:0] res;
        big = ({1'b0, b} >= SH_LIM);
        sh  = b[SHW-1:0];
        res = '0;
        case (o)
            OP_SHL:  res = big ? '0 : (a << sh);
            OP_SHR:  res = big ? '0 : (a >> sh);
            default: res = big ? {NUBITS{a[NUBITS-1]}} : NUBITS'($signed(a) >>> sh);
        endcase
        return res;
    endfunction

    // All operations other than DIV/MOD/NRM.
    function automatic logic [NUBITS-1:0] alu1(input logic [4:0] o, input logic [NUBITS-1:0] a,
                                                input logic [NUBITS-1:0] b);
        logic signed [NUBITS-1:0] sa;
        logic signed [NUBITS-1:0] sb;
        logic [NUBITS-1:0]        res;
        sa  = a;
        sb  = b;
        res = '0;
        case (o)
            OP_NOP:  res = b;
            OP_LOAD: res = a;
            OP_ADD:  res = a + b;
            OP_MLT:  res = a * b;
            OP_NEG:  res = -b;
            OP_ABS:  res = mag(b);
            OP_PST:  res = b[NUBITS-1] ? '0 : b;
            OP_SGN:  res = a[NUBITS-1] ? -mag(b) : mag(b);
            OP_OR:   res = a | b;
            OP_AND:  res = a & b;
            OP_INV:  res = ~b;
            OP_XOR:  res = a ^ b;
            OP_LES:  res[0] = (sa < sb);
            OP_GRE:  res[0] = (sa > sb);
            OP_EQU:  res[0] = (a == b);
            OP_LIN:  res[0] = (b == '0);
            OP_LAN:  res[0] = (a != '0) && (b != '0);
            OP_LOR:  res[0] = (a != '0) || (b != '0);
            OP_SHL, OP_SHR, OP_SRS: res = shift_op(o, a, b);
            default: res = '0;
        endcase
        return res;
    endfunction

`ifndef ULA_FX_SEQ_DIV_EN
    function automatic logic [NUBITS-1:0] div_c(input logic mod_sel, input logic [NUBITS-1:0] n,
                                                 input logic [NUBITS-1:0] d);
        logic [NUBITS-1:0] nm;
        logic [NUBITS-1:0] dm;
        nm = mag(n);
        dm = mag(d);
        return apply_sign(mod_sel, n[NUBITS-1], d[NUBITS-1], nm / dm, nm % dm);
    endfunction
`endif

    logic              is_div;
    logic              div_zero;
    logic [NUBITS-1:0] dvd;
    logic [NUBITS-1:0] dvs;
    logic [NUBITS-1:0] sc_res;
    logic              sc_dbz;

    assign is_div   = (op == OP_DIV) || (op == OP_MOD) || (op == OP_NRM);
    assign div_zero = ((op == OP_DIV) || (op == OP_MOD)) && (in2 == '0);
    assign dvd      = (op == OP_NRM) ? in2 : in1;
    assign dvs      = (op == OP_NRM) ? GAIN : in2;
    assign is_zero  = (out == '0);

    // Result of anything that completes in one cycle, including zero divisors.
    always_comb begin
        sc_res = alu1(op, in1, in2);
        sc_dbz = 1'b0;
        if (div_zero) begin
            sc_dbz = 1'b1;
            sc_res = (op == OP_MOD) ? in1 : (in1[NUBITS-1] ? SMIN : SMAX);
        end
`ifndef ULA_FX_SEQ_DIV_EN
        else if (is_div) begin
            sc_res = div_c(op == OP_MOD, dvd, dvs);
        end
`endif
    end

`ifdef ULA_FX_SEQ_DIV_EN
    typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;
    localparam int CW = (SHW > 0) ? SHW : 1;

    state_t            state;
    state_t            state_nxt;
    logic [CW-1:0]     cnt;
    logic [NUBITS-1:0] rem;
    logic [NUBITS-1:0] quo;
    logic [NUBITS-1:0] dvs_mag;
    logic              neg_n;
    logic              neg_d;
    logic              is_mod;
    logic [NUBITS:0]   shifted;
    logic [NUBITS:0]   trial;
    logic              accept;
    logic              launch;

    assign busy    = (state != IDLE);
    assign accept  = start && (state == IDLE);
    assign launch  = accept && is_div && !div_zero;
    // quo starts as |dividend| and shifts its bits into the partial remainder
    // while quotient bits fill it from the bottom.
    assign shifted = {rem, quo[NUBITS-1]};
    assign trial   = shifted - {1'b0, dvs_mag};

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (launch) state_nxt = ITER;
            ITER:    if (cnt == CW'(NUBITS-1)) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            rem         <= '0;
            quo         <= '0;
            dvs_mag     <= '0;
            neg_n       <= 1'b0;
            neg_d       <= 1'b0;
            is_mod      <= 1'b0;
            out         <= '0;
            valid       <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            state <= state_nxt;
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (launch) begin
                        rem     <= '0;
                        quo     <= mag(dvd);
                        dvs_mag <= mag(dvs);
                        neg_n   <= dvd[NUBITS-1];
                        neg_d   <= dvs[NUBITS-1];
                        is_mod  <= (op == OP_MOD);
                        cnt     <= '0;
                    end else if (accept) begin
                        out         <= sc_res;
                        div_by_zero <= sc_dbz;
                        valid       <= 1'b1;
                    end
                end
                ITER: begin
                    // A borrow in trial means the divisor did not fit: keep the
                    // shifted remainder and record a 0 quotient bit.
                    rem <= trial[NUBITS] ? shifted[NUBITS-1:0] : trial[NUBITS-1:0];
                    quo <= {quo[NUBITS-2:0], ~trial[NUBITS]};
                    cnt <= cnt + CW'(1);
                end
                FIX: begin
                    out         <= apply_sign(is_mod, neg_n, neg_d, quo, rem);
                    div_by_zero <= 1'b0;
                    valid       <= 1'b1;
                end
                default: ;
            endcase
        end
    end
`else
    assign busy = 1'b0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out         <= '0;
            valid       <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            valid <= start;
            if (start) begin
                out         <= sc_res;
                div_by_zero <= sc_dbz;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ula_fx_seq.sv
module tb_ula_fx_seq;
    localparam int N = 32;
`ifdef ULA_FX_SEQ_DIV_EN
    localparam int   DLAT     = N + 1;
    localparam int   DBUSY    = N + 1;
    localparam logic EXP_BUSY = 1'b1;
`else
    localparam int   DLAT     = 0;
    localparam int   DBUSY    = 0;
    localparam logic EXP_BUSY = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic [4:0]   op;
    logic [N-1:0] in1;
    logic [N-1:0] in2;
    logic         start;
    logic         busy;
    logic         valid;
    logic [N-1:0] out;
    logic         is_zero;
    logic         div_by_zero;

    int n_tests = 0;
    int n_fail  = 0;
    int lat;
    int bcnt;
    int vcnt;

    always #5 clk = ~clk;

    ula_fx_seq #(.NUBITS(N), .NUGAIN(64)) dut (
        .clk(clk), .rst(rst), .op(op), .in1(in1), .in2(in2), .start(start),
        .busy(busy), .valid(valid), .out(out), .is_zero(is_zero), .div_by_zero(div_by_zero)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one request at the current (post-edge) time and wait for valid.
    // lat counts edges after the accepting edge; bcnt counts busy samples.
    task automatic do_op(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                         output int l, output int bc);
        op = o; in1 = a; in2 = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        l = 0;
        bc = 0;
        while (!valid && l < 100) begin
            if (busy) bc++;
            @(posedge clk); #1;
            l++;
        end
        if (!valid) chk("timeout", 32'(valid), 32'd1);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; op = '0; in1 = '0; in2 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out", out, 32'h0);
        chk("rst_is_zero", 32'(is_zero), 32'd1);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_dbz", 32'(div_by_zero), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        do_op(5'd2, 32'd3, 32'd4, lat, bcnt);
        chk("add_out", out, 32'd7);
        chk("add_lat", 32'(lat), 32'd0);
        @(posedge clk); #1;
        chk("valid_pulse", 32'(valid), 32'd0);

        do_op(5'd4, 32'hFFFF_FFF9, 32'd2, lat, bcnt);
        chk("div_m7_2", out, 32'hFFFF_FFFD);
        chk("div_lat", 32'(lat), 32'(DLAT));
        chk("div_busy_cycles", 32'(bcnt), 32'(DBUSY));
        chk("div_dbz", 32'(div_by_zero), 32'd0);
        chk("div_busy_after", 32'(busy), 32'd0);

        do_op(5'd5, 32'hFFFF_FFF9, 32'd2, lat, bcnt);
        chk("mod_m7_2", out, 32'hFFFF_FFFF);
        chk("mod_lat", 32'(lat), 32'(DLAT));

        do_op(5'd4, 32'd5, 32'd0, lat, bcnt);
        chk("div_5_0", out, 32'h7FFF_FFFF);
        chk("div_5_0_dbz", 32'(div_by_zero), 32'd1);
        chk("div_5_0_lat", 32'(lat), 32'd0);

        do_op(5'd5, 32'hFFFF_FFFB, 32'd0, lat, bcnt);
        chk("mod_m5_0", out, 32'hFFFF_FFFB);
        chk("mod_m5_0_dbz", 32'(div_by_zero), 32'd1);

        do_op(5'd7, 32'd999, 32'hFFFF_FF7E, lat, bcnt);
        chk("nrm_m130", out, 32'hFFFF_FFFE);
        chk("nrm_dbz", 32'(div_by_zero), 32'd0);

        do_op(5'd4, 32'h8000_0000, 32'hFFFF_FFFF, lat, bcnt);
        chk("div_min_m1", out, 32'h8000_0000);
        chk("div_min_m1_dbz", 32'(div_by_zero), 32'd0);

        do_op(5'd5, 32'h8000_0000, 32'hFFFF_FFFF, lat, bcnt);
        chk("mod_min_m1", out, 32'h0);
        chk("mod_min_m1_zero", 32'(is_zero), 32'd1);

        // Start while busy must be ignored; start in the valid cycle is accepted.
        op = 5'd4; in1 = 32'd100; in2 = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        if (busy) begin
            op = 5'd2; in1 = 32'd3; in2 = 32'd4; start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
        end
        lat = 0;
        while (!valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("div_ignore_valid", 32'(valid), 32'd1);
        chk("div_100_7", out, 32'd14);
        op = 5'd2; in1 = 32'd3; in2 = 32'd4; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("add_after_div", out, 32'd7);
        chk("add_after_div_valid", 32'(valid), 32'd1);

        do_op(5'd3, 32'hFFFF_FFFD, 32'd5, lat, bcnt);
        chk("mlt_m3_5", out, 32'hFFFF_FFF1);
        do_op(5'd6, 32'd0, 32'h8000_0000, lat, bcnt);
        chk("neg_min", out, 32'h8000_0000);
        do_op(5'd15, 32'hFFFF_FFFF, 32'd1, lat, bcnt);
        chk("les_m1_1", out, 32'd1);
        do_op(5'd23, 32'h8000_0000, 32'd40, lat, bcnt);
        chk("srs_40", out, 32'hFFFF_FFFF);
        do_op(5'd22, 32'h8000_0000, 32'd31, lat, bcnt);
        chk("shr_31", out, 32'd1);
        do_op(5'd21, 32'd1, 32'd32, lat, bcnt);
        chk("shl_32", out, 32'h0);
        chk("shl_32_zero", 32'(is_zero), 32'd1);
        do_op(5'd18, 32'd0, 32'd2, lat, bcnt);
        chk("lin_2", out, 32'd0);
        do_op(5'd18, 32'd0, 32'd0, lat, bcnt);
        chk("lin_0", out, 32'd1);
        do_op(5'd27, 32'd5, 32'd6, lat, bcnt);
        chk("op27", out, 32'd0);
        chk("op27_lat", 32'(lat), 32'd0);
        chk("op27_valid", 32'(valid), 32'd1);

        // Reset in the middle of a division.
        do_op(5'd2, 32'd3, 32'd4, lat, bcnt);
        op = 5'd4; in1 = 32'd1000; in2 = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("busy_before_rst", 32'(busy), 32'(EXP_BUSY));
        rst = 1'b1;
        #1;
        chk("abort_out", out, 32'h0);
        chk("abort_is_zero", 32'(is_zero), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_valid", 32'(valid), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        vcnt = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (valid) vcnt++;
        end
        chk("abort_no_valid", 32'(vcnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
